// File: rtl/attendant_panel.sv
// attendant_panel: latches seat calls, blinks an alert lamp and serves one call at a time
// in round-robin order under debounced accept (BTNU) and complete (BTND) buttons.
module attendant_panel #(
    parameter int N_SEATS         = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_HALF      = 25_000_000
) (
    input  logic                       CLK100MHZ,
    input  logic                       CPU_RESETN,
    input  logic [N_SEATS-1:0]         call_req,
    input  logic                       BTNU,
    input  logic                       BTND,
    output logic [N_SEATS-1:0]         pending,
    output logic                       serving_valid,
    output logic [$clog2(N_SEATS)-1:0] serving_seat,
    output logic                       alert_led,
    output logic                       busy_led
);
    localparam int SW = $clog2(N_SEATS);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [1:0] IDLE = 2'd0, ALERT = 2'd1, SERVING = 2'd2;

    logic [N_SEATS-1:0] req_s1, req_s2, req_s3, rise, fall, clr;
    logic [1:0] btn_s1, btn_s2, deb, deb_q, warm, state;
    logic [1:0][DW-1:0] cnt;
    logic [BW-1:0] blink;
    logic [SW-1:0] last, pick;
    logic acc, cmp;

    // edges are only trusted once req_s3 holds a real sample, so levels held across reset never latch
    assign rise = (warm == 2'd3) ? req_s2 & ~req_s3 : '0;
    assign fall = (warm == 2'd3) ? ~req_s2 & req_s3 : '0;
    assign acc = deb[0] & ~deb_q[0];
    assign cmp = deb[1] & ~deb_q[1];
    assign clr = (state == ALERT && acc && |pending) ? N_SEATS'(1) << pick : '0;
    assign serving_valid = state == SERVING;
    assign busy_led = state == SERVING;

    always_comb begin
        pick = last;
        for (int k = N_SEATS; k >= 1; k--)
            if (pending[SW'((int'(last) + k) % N_SEATS)]) pick = SW'((int'(last) + k) % N_SEATS);
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            req_s1 <= '0;
            req_s2 <= '0;
            req_s3 <= '0;
            btn_s1 <= '0;
            btn_s2 <= '0;
            deb    <= '0;
            deb_q  <= '0;
            cnt    <= '0;
            warm   <= '0;
        end else begin
            req_s1 <= call_req;
            req_s2 <= req_s1;
            req_s3 <= req_s2;
            btn_s1 <= {BTND, BTNU};
            btn_s2 <= btn_s1;
            deb_q  <= deb;
            warm   <= (warm == 2'd3) ? warm : warm + 2'd1;
            for (int i = 0; i < 2; i++)
                if (btn_s2[i] == deb[i]) cnt[i] <= '0;
                else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt[i] <= '0;
                    deb[i] <= btn_s2[i];
                end else cnt[i] <= cnt[i] + 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state        <= IDLE;
            pending      <= '0;
            serving_seat <= '0;
            last         <= SW'(N_SEATS - 1);
            alert_led    <= 1'b0;
            blink        <= '0;
        end else begin
            pending <= (pending & ~fall & ~clr) | rise;
            blink   <= '0;
            if (state == IDLE) begin
                if (|pending) begin
                    state     <= ALERT;
                    alert_led <= 1'b1;
                end
            end else if (state == ALERT) begin
                if (~|pending) begin
                    state     <= IDLE;
                    alert_led <= 1'b0;
                end else if (acc) begin
                    state        <= SERVING;
                    serving_seat <= pick;
                    last         <= pick;
                    alert_led    <= 1'b0;
                end else if (blink == BW'(BLINK_HALF - 1)) alert_led <= ~alert_led;
                else blink <= blink + 1'b1;
            end else if (cmp) begin
                state        <= |pending ? ALERT : IDLE;
                serving_seat <= '0;
                alert_led    <= |pending;
            end
        end
    end
endmodule

// File: tb/tb_attendant_panel.sv
// tb_attendant_panel: vector table, directed corner sequences and randomized traffic,
// all checked every cycle against a behavioural model of the attendant panel.
module tb_attendant_panel;
    localparam int N = 8, D = 4, B = 8;

    logic clk = 1'b0, rst_n = 1'b0, btnu = 1'b0, btnd = 1'b0;
    logic [N-1:0] call_req = '0, pending;
    logic serving_valid, alert_led, busy_led;
    logic [2:0] serving_seat;
    int tests = 0, fails = 0;

    typedef struct {
        logic [N-1:0] req;
        logic u, d;
        int cyc;
        logic [N-1:0] pend;
        logic valid;
        int seat;
        logic alert;
    } vec_t;
    vec_t tbl[$];

    int n, m_entry, m_last, m_seat;
    logic [N-1:0] rq[$];
    logic bu[$], bd[$];
    logic deb_u, deb_d, acc_p, cmp_p, m_serv, m_alerting;
    logic [N-1:0] m_pend;

    always #5 clk = ~clk;

    attendant_panel #(.N_SEATS(N), .DEBOUNCE_CYCLES(D), .BLINK_HALF(B)) dut (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .call_req(call_req), .BTNU(btnu), .BTND(btnd),
        .pending(pending), .serving_valid(serving_valid), .serving_seat(serving_seat),
        .alert_led(alert_led), .busy_led(busy_led)
    );

    function automatic void m_reset();
        n = 0;
        rq.delete();
        bu.delete();
        bd.delete();
        for (int j = 0; j < D + 2; j++) begin
            bu.push_back(1'b0);
            bd.push_back(1'b0);
        end
        deb_u = 0; deb_d = 0; acc_p = 0; cmp_p = 0;
        m_serv = 0; m_alerting = 0; m_entry = 0; m_last = N - 1; m_seat = 0; m_pend = '0;
    endfunction

    // one clock edge: queues hold raw samples, index 2 onward is what the synchronizers show
    function automatic void m_step();
        logic acc, cmp, flip_u, flip_d, found;
        logic [N-1:0] rise, fall, clr, old;
        acc = acc_p; cmp = cmp_p; acc_p = 0; cmp_p = 0;
        n++;
        rq.push_front(call_req);
        bu.push_front(btnu);
        bd.push_front(btnd);
        if (rq.size() > 4) void'(rq.pop_back());
        void'(bu.pop_back());
        void'(bd.pop_back());
        flip_u = 1; flip_d = 1;
        for (int j = 2; j < D + 2; j++) begin
            flip_u &= bu[j] != deb_u;
            flip_d &= bd[j] != deb_d;
        end
        if (flip_u) begin deb_u = ~deb_u; acc_p = deb_u; end
        if (flip_d) begin deb_d = ~deb_d; cmp_p = deb_d; end
        rise = '0; fall = '0; clr = '0; old = m_pend;
        if (n >= 4) begin
            rise = rq[2] & ~rq[3];
            fall = ~rq[2] & rq[3];
        end
        if (m_serv) begin
            if (cmp) begin
                m_serv = 0; m_seat = 0;
                if (old != 0) begin m_alerting = 1; m_entry = n; end
            end
        end else if (m_alerting) begin
            if (old == 0) m_alerting = 0;
            else if (acc) begin
                found = 0;
                for (int k = 1; k <= N; k++)
                    if (!found && old[(m_last + k) % N]) begin found = 1; m_seat = (m_last + k) % N; end
                m_last = m_seat; clr[m_seat] = 1'b1; m_serv = 1; m_alerting = 0;
            end
        end else if (old != 0) begin m_alerting = 1; m_entry = n; end
        m_pend = (old & ~fall & ~clr) | rise;
    endfunction

    function automatic logic m_alert();
        return m_alerting && (((n - m_entry) / B) % 2 == 0);
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_reset();
        else m_step();

    task automatic tick();
        @(negedge clk);
        tests++;
        if (pending !== m_pend || serving_valid !== m_serv || busy_led !== m_serv ||
            serving_seat !== 3'(m_seat) || alert_led !== m_alert()) begin
            fails++;
            $display("FAIL model @%0t: pend %h want %h, valid %b want %b, busy %b, seat %0d want %0d, alert %b want %b",
                     $time, pending, m_pend, serving_valid, m_serv, busy_led, serving_seat, m_seat, alert_led, m_alert());
        end
    endtask

    task automatic expect_out(input string name, input logic [N-1:0] p, input logic v, input int s, input logic a);
        tests++;
        if (pending !== p || serving_valid !== v || busy_led !== v || serving_seat !== 3'(s) || alert_led !== a) begin
            fails++;
            $display("FAIL %s: pend %h want %h, valid %b want %b, busy %b, seat %0d want %0d, alert %b want %b",
                     name, pending, p, serving_valid, v, busy_led, serving_seat, s, alert_led, a);
        end
    endtask

    function automatic void add(input logic [N-1:0] r, input logic u, input logic d, input int c,
                                input logic [N-1:0] p, input logic v, input int s, input logic a);
        vec_t e;
        e.req = r; e.u = u; e.d = d; e.cyc = c; e.pend = p; e.valid = v; e.seat = s; e.alert = a;
        tbl.push_back(e);
    endfunction

    initial begin
        int rises, ucnt, dcnt, idx;
        logic prev;
        m_reset();
        add(8'h00, 0, 0, 20, 8'h00, 0, 0, 0);
        add(8'h81, 0, 0,  3, 8'h81, 0, 0, 0);
        add(8'h81, 0, 0,  1, 8'h81, 0, 0, 1);
        add(8'h81, 1, 0,  6, 8'h81, 0, 0, 1);
        add(8'h81, 1, 0,  1, 8'h80, 1, 0, 0);
        add(8'h81, 0, 0, 10, 8'h80, 1, 0, 0);
        add(8'h81, 0, 1,  6, 8'h80, 1, 0, 0);
        add(8'h81, 0, 1,  1, 8'h80, 0, 0, 1);
        add(8'h81, 0, 0, 10, 8'h80, 0, 0, 0);
        add(8'h81, 1, 0,  7, 8'h00, 1, 7, 0);
        add(8'h81, 0, 0, 10, 8'h00, 1, 7, 0);
        add(8'h81, 0, 1,  7, 8'h00, 0, 0, 0);
        add(8'h00, 0, 0, 10, 8'h00, 0, 0, 0);
        add(8'h20, 0, 0,  4, 8'h20, 0, 0, 1);
        add(8'h20, 1, 0,  6, 8'h20, 0, 0, 1);
        add(8'h20, 1, 0,  1, 8'h00, 1, 5, 0);
        add(8'h28, 1, 0,  4, 8'h08, 1, 5, 0);
        add(8'h28, 1, 1,  7, 8'h08, 0, 0, 1);
        add(8'h28, 1, 0, 20, 8'h08, 0, 0, 1);
        add(8'h28, 0, 0, 10, 8'h08, 0, 0, 0);
        add(8'h20, 0, 0,  3, 8'h00, 0, 0, 1);
        add(8'h20, 0, 0,  1, 8'h00, 0, 0, 0);
        add(8'h00, 0, 0,  5, 8'h00, 0, 0, 0);
        add(8'h20, 0, 0,  4, 8'h20, 0, 0, 1);
        add(8'h20, 1, 0,  7, 8'h00, 1, 5, 0);
        add(8'h00, 0, 0,  4, 8'h00, 1, 5, 0);
        add(8'h20, 0, 0,  4, 8'h20, 1, 5, 0);
        add(8'h00, 0, 0,  4, 8'h00, 1, 5, 0);
        add(8'h20, 0, 0,  4, 8'h20, 1, 5, 0);

        @(negedge clk);
        expect_out("reset", '0, 0, 0, 0);
        rst_n = 1'b1;
        foreach (tbl[i]) begin
            call_req = tbl[i].req; btnu = tbl[i].u; btnd = tbl[i].d;
            repeat (tbl[i].cyc) tick();
            expect_out($sformatf("vec%0d", i), tbl[i].pend, tbl[i].valid, tbl[i].seat, tbl[i].alert);
        end

        // reset in the middle of a service, with seat 5 still holding its call
        #2 rst_n = 1'b0;
        #1 expect_out("async_reset", '0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        expect_out("held_after_reset", '0, 0, 0, 0);
        call_req = '0;
        repeat (5) tick();
        call_req = 8'h20;
        repeat (4) tick();
        expect_out("relatch", 8'h20, 0, 0, 1);

        for (int i = 0; i < 10; i++) begin
            btnu = (i % 2 == 0);
            tick();
        end
        btnu = 1'b1;
        repeat (4) tick();
        btnu = 1'b0;
        rises = 0; prev = serving_valid;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (serving_valid && !prev) rises++;
            prev = serving_valid;
        end
        tests++;
        if (rises != 1 || serving_seat !== 3'd5) begin
            fails++;
            $display("FAIL bounce: accepts %0d want 1, seat %0d want 5", rises, serving_seat);
        end

        call_req = 8'h23;
        repeat (4) tick();
        btnd = 1'b1;
        repeat (7) tick();
        btnd = 1'b0;
        expect_out("complete_to_alert", 8'h03, 0, 0, 1);
        btnu = 1'b1;
        rises = 0; prev = serving_valid;
        for (int i = 0; i < 100; i++) begin
            if (i == 40) btnd = 1'b1;
            if (i == 48) btnd = 1'b0;
            tick();
            if (serving_valid && !prev) rises++;
            prev = serving_valid;
        end
        btnu = 1'b0;
        tests++;
        if (rises != 1 || serving_valid !== 1'b0 || pending !== 8'h02) begin
            fails++;
            $display("FAIL held_press: accepts %0d want 1, valid %b want 0, pend %h want 02", rises, serving_valid, pending);
        end

        ucnt = 0; dcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                idx = $urandom_range(0, N - 1);
                call_req[idx] = ~call_req[idx];
            end
            if (ucnt == 0 && $urandom_range(0, 29) == 0) ucnt = $urandom_range(1, 12);
            if (dcnt == 0 && $urandom_range(0, 49) == 0) dcnt = $urandom_range(1, 12);
            btnu = ucnt > 0;
            btnd = dcnt > 0;
            if (ucnt > 0) ucnt--;
            if (dcnt > 0) dcnt--;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
